sys_bus_mem_responder: RTL and testbench

- Memory-side responder for the cache's system-bus handshake: read-address, read-data, write-address, write-data and write-response channels.
- Serves an internal word-addressed memory array with a programmable access latency.
- Sits behind the bus and answers the cache controller's line fills and write-through stores; also usable as the bench memory model.

---
 rtl/sys_bus_mem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_sys_bus_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_mem_responder.sv
// sys_bus_mem_responder
// Memory-side responder for the cache system bus: five-channel valid/ready
// handshake (read address, read data, write address, write data, write
// response) in front of a word-addressed 32-bit memory. Responses are
// produced LATENCY+1 cycles after request acceptance.
// Only one transaction is outstanding at a time.
//
// Optional build macro: RESP_ERR_EN
//   Defined:   addresses with nonzero bits above bit ADDR_W+1 are out of
//              range. Out-of-range writes leave memory untouched and respond
//              with 32'h1. Out-of-range reads return 32'hDEAD_BEEF.
//   Undefined: the upper address bits alias onto the array, and every
//              response is OKAY (0).
module sys_bus_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readAddr_valid,
    output logic        readAddr_ready,
    input  logic [31:0] readAddr,
    output logic        readData_valid,
    input  logic        readData_ready,
    output logic [31:0] readData,
    input  logic        writeAddr_valid,
    output logic        writeAddr_ready,
    input  logic [31:0] writeAddr,
    input  logic        writeData_valid,
    output logic        writeData_ready,
    input  logic [31:0] writeData,
    input  logic [3:0]  writeStrb,
    output logic        writeResp_valid,
    input  logic        writeResp_ready,
    output logic [31:0] writeResp_msg
);

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        W_COLLECT,
        W_WAIT,
        W_RESP,
        R_WAIT,
        R_DATA
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic              err_reg;
    logic              have_addr_reg;
    logic              have_data_reg;
    logic [31:0]       rd_word;

    logic terminal;
    logic rd_accept;
    logic aw_fire;
    logic w_fire;
    logic mem_we;
    logic mem_re;

    // True when an address falls outside the implemented array.
    function automatic logic out_of_range(input logic [31:0] a);
`ifdef RESP_ERR_EN
        return |(a >> (ADDR_W + 2));
`else
        return 1'b0;
`endif
    endfunction

    assign terminal = (cnt_reg == LAT);

    // A read in IDLE wins the cycle; any write handshake on that edge is ignored.
    assign rd_accept = readAddr_ready & readAddr_valid;
    assign aw_fire   = writeAddr_ready & writeAddr_valid &
                       ~((state_reg == IDLE) & readAddr_valid);
    assign w_fire    = writeData_ready & writeData_valid &
                       ~((state_reg == IDLE) & readAddr_valid);

    assign mem_we = (state_reg == W_WAIT) & terminal & ~err_reg;
    assign mem_re = (state_reg == R_WAIT) & terminal;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the readies, which depend on state only.
    always_comb begin
        state_next      = state_reg;
        readAddr_ready  = 1'b0;
        writeAddr_ready = 1'b0;
        writeData_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                readAddr_ready  = ~rst;
                writeAddr_ready = ~rst;
                writeData_ready = ~rst;
                if (readAddr_valid) begin
                    state_next = R_WAIT;
                end else if (writeAddr_valid && writeData_valid) begin
                    state_next = W_WAIT;
                end else if (writeAddr_valid || writeData_valid) begin
                    state_next = W_COLLECT;
                end
            end
            W_COLLECT: begin
                writeAddr_ready = ~have_addr_reg;
                writeData_ready = ~have_data_reg;
                if ((!have_addr_reg && writeAddr_valid) ||
                    (!have_data_reg && writeData_valid)) begin
                    state_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (terminal) begin
                    state_next = W_RESP;
                end
            end
            R_WAIT: begin
                if (terminal) begin
                    state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (readData_ready) begin
                    state_next = IDLE;
                end
            end
            W_RESP: begin
                if (writeResp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and the latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= 4'd0;
            idx_reg       <= '0;
            wdata_reg     <= 32'd0;
            wstrb_reg     <= 4'd0;
            err_reg       <= 1'b0;
            have_addr_reg <= 1'b0;
            have_data_reg <= 1'b0;
        end else begin
            if (((state_reg == R_WAIT) || (state_reg == W_WAIT)) && !terminal) begin
                cnt_reg <= cnt_reg + 4'd1;
            end else begin
                cnt_reg <= 4'd0;
            end

            if (state_reg == IDLE) begin
                have_addr_reg <= aw_fire;
                have_data_reg <= w_fire;
            end else if (state_reg == W_COLLECT) begin
                if (aw_fire) have_addr_reg <= 1'b1;
                if (w_fire)  have_data_reg <= 1'b1;
            end

            if (rd_accept) begin
                idx_reg <= readAddr[ADDR_W+1:2];
                err_reg <= out_of_range(readAddr);
            end else if (aw_fire) begin
                idx_reg <= writeAddr[ADDR_W+1:2];
                err_reg <= out_of_range(writeAddr);
            end

            if (w_fire) begin
                wdata_reg <= writeData;
                wstrb_reg <= writeStrb;
            end
        end
    end

    // One byte-wide array per lane so each strobe maps to its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            // Strobed byte write at W_WAIT exit; registered read at R_WAIT exit.
            always_ff @(posedge clk) begin
                if (mem_we && wstrb_reg[gi]) begin
                    lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
                end
                if (mem_re) begin
                    lane_q <= lane_mem[idx_reg];
                end
            end

            assign rd_word[8*gi +: 8] = lane_q;
        end
    endgenerate

    // Response channels are driven from state so they stay stable until handshake.
    assign readData_valid  = (state_reg == R_DATA);
    assign writeResp_valid = (state_reg == W_RESP);
`ifdef RESP_ERR_EN
    assign readData      = (state_reg != R_DATA) ? 32'd0 :
                           (err_reg ? 32'hDEAD_BEEF : rd_word);
    assign writeResp_msg = (state_reg == W_RESP) ? {31'd0, err_reg} : 32'd0;
`else
    assign readData      = (state_reg == R_DATA) ? rd_word : 32'd0;
    assign writeResp_msg = 32'd0;
`endif

endmodule

// File: tb/tb_sys_bus_mem_responder.sv
// Directed testbench for sys_bus_mem_responder (ADDR_W=10, LATENCY=2).
// Honours RESP_ERR_EN for the out-of-range address case.
module tb_sys_bus_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        readAddr_valid;
    logic        readAddr_ready;
    logic [31:0] readAddr;
    logic        readData_valid;
    logic        readData_ready;
    logic [31:0] readData;
    logic        writeAddr_valid;
    logic        writeAddr_ready;
    logic [31:0] writeAddr;
    logic        writeData_valid;
    logic        writeData_ready;
    logic [31:0] writeData;
    logic [3:0]  writeStrb;
    logic        writeResp_valid;
    logic        writeResp_ready;
    logic [31:0] writeResp_msg;

    int n_cmp = 0;
    int n_bad = 0;

    sys_bus_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .readAddr_valid  (readAddr_valid),
        .readAddr_ready  (readAddr_ready),
        .readAddr        (readAddr),
        .readData_valid  (readData_valid),
        .readData_ready  (readData_ready),
        .readData        (readData),
        .writeAddr_valid (writeAddr_valid),
        .writeAddr_ready (writeAddr_ready),
        .writeAddr       (writeAddr),
        .writeData_valid (writeData_valid),
        .writeData_ready (writeData_ready),
        .writeData       (writeData),
        .writeStrb       (writeStrb),
        .writeResp_valid (writeResp_valid),
        .writeResp_ready (writeResp_ready),
        .writeResp_msg   (writeResp_msg)
    );

    always #5 clk = ~clk;

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!writeResp_valid && cyc < 20);
    endtask

    task automatic wait_rdata(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!readData_valid && cyc < 20);
    endtask

    task automatic finish_write(input string tag, input logic [31:0] exp_msg);
        int c;
        wait_resp(c);
        check({tag, "_lat"}, 32'(c), 32'(LAT + 1));
        check({tag, "_msg"}, writeResp_msg, exp_msg);
        writeResp_ready = 1'b1;
        step();
        writeResp_ready = 1'b0;
        check({tag, "_done"}, {31'd0, writeResp_valid}, 32'd0);
    endtask

    task automatic write_both(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] exp_msg);
        writeAddr       = a;
        writeData       = d;
        writeStrb       = s;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        step();
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        finish_write(tag, exp_msg);
    endtask

    task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int c;
        readAddr       = a;
        readAddr_valid = 1'b1;
        step();
        readAddr_valid = 1'b0;
        wait_rdata(c);
        check({tag, "_lat"}, 32'(c), 32'(LAT + 1));
        check({tag, "_data"}, readData, exp);
        readData_ready = 1'b1;
        step();
        readData_ready = 1'b0;
    endtask

    initial begin
        int c;
        rst             = 1'b1;
        readAddr_valid  = 1'b0;
        readAddr        = 32'd0;
        readData_ready  = 1'b0;
        writeAddr_valid = 1'b0;
        writeAddr       = 32'd0;
        writeData_valid = 1'b0;
        writeData       = 32'd0;
        writeStrb       = 4'd0;
        writeResp_ready = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_handshake", {27'd0, readAddr_ready, writeAddr_ready, writeData_ready,
                                readData_valid, writeResp_valid}, 32'd0);
        check("rst_rdata", readData, 32'd0);
        check("rst_msg", writeResp_msg, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_readies", {29'd0, readAddr_ready, writeAddr_ready, writeData_ready}, 32'd7);

        // Full write then read back.
        write_both("w10", 32'h10, 32'h1234_5678, 4'hF, 32'd0);
        read_word("r10", 32'h10, 32'h1234_5678);

        // Partial strobe merge.
        write_both("w40", 32'h40, 32'h1122_3344, 4'hF, 32'd0);
        write_both("w40s", 32'h40, 32'hAABB_CCDD, 4'b0101, 32'd0);
        read_word("r40s", 32'h40, 32'h11BB_33DD);

        // Zero strobe: no change, still OKAY.
        write_both("w40z", 32'h40, 32'hFFFF_FFFF, 4'h0, 32'd0);
        read_word("r40z", 32'h40, 32'h11BB_33DD);

        // Address three cycles ahead of data.
        writeAddr       = 32'h80;
        writeAddr_valid = 1'b1;
        step();
        writeAddr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("coll_readies", {30'd0, writeAddr_ready, writeData_ready}, 32'd1);
            if (i < 2) step();
        end
        writeData       = 32'hCAFE_F00D;
        writeStrb       = 4'hF;
        writeData_valid = 1'b1;
        step();
        writeData_valid = 1'b0;
        check("coll_wdready", {31'd0, writeData_ready}, 32'd0);
        finish_write("w80", 32'd0);
        read_word("r80", 32'h80, 32'hCAFE_F00D);

        // Read data held while requester stalls.
        readAddr       = 32'h10;
        readAddr_valid = 1'b1;
        step();
        readAddr_valid = 1'b0;
        wait_rdata(c);
        check("stall_lat", 32'(c), 32'(LAT + 1));
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {30'd0, readData_valid, readAddr_ready}, 32'd2);
            check("stall_data", readData, 32'h1234_5678);
            step();
        end
        readData_ready = 1'b1;
        step();
        readData_ready = 1'b0;
        check("stall_done", {30'd0, readData_valid, readAddr_ready}, 32'd1);

        // Read beats simultaneous write; reset during W_WAIT drops the write.
        write_both("w20", 32'h20, 32'h0BAD_0BAD, 4'hF, 32'd0);
        readAddr        = 32'h10;
        readAddr_valid  = 1'b1;
        writeAddr       = 32'h20;
        writeData       = 32'h5555_5555;
        writeStrb       = 4'hF;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        step();
        readAddr_valid = 1'b0;
        check("prio_wready", {30'd0, writeAddr_ready, writeData_ready}, 32'd0);
        wait_rdata(c);
        check("prio_rdata", readData, 32'h1234_5678);
        readData_ready = 1'b1;
        step();
        readData_ready = 1'b0;
        check("prio_idle", {30'd0, writeAddr_ready, writeData_ready}, 32'd3);
        step();
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        check("prio_waccept", {30'd0, writeAddr_ready, writeData_ready}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("midrst_outs", {27'd0, readAddr_ready, writeAddr_ready, writeData_ready,
                              readData_valid, writeResp_valid}, 32'd0);
        check("midrst_msg", writeResp_msg, 32'd0);
        step();
        step();
        check("midrst_hold", {31'd0, writeResp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        read_word("r20", 32'h20, 32'h0BAD_0BAD);

        // Address above the array.
        write_both("w0", 32'h0, 32'h0102_0304, 4'hF, 32'd0);
`ifdef RESP_ERR_EN
        write_both("woor", 32'h0000_1000, 32'h7777_7777, 4'hF, 32'd1);
        read_word("roor", 32'h0000_1000, 32'hDEAD_BEEF);
        read_word("r0", 32'h0, 32'h0102_0304);
`else
        write_both("walias", 32'h0000_1000, 32'h7777_7777, 4'hF, 32'd0);
        read_word("r0", 32'h0, 32'h7777_7777);
        read_word("ralias", 32'h0000_1010, 32'h1234_5678);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
